// File: rtl/ui_pkg.sv
// Shared UI front-end definitions: debounce FSM states,
// button channel indices and the default stability window.
package ui_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM_HI = 2'd1,
    HIGH   = 2'd2,
    ARM_LO = 2'd3
  } db_state_e;

  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_RST  = 2;

  localparam int DEF_STABLE_CYCLES = 500000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stability counter and
// debounce FSM. Ports: clk, rst_n, btn_raw_i -> btn_level_o/rise_o/fall_o.
module debounce_channel
  import ui_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic btn_level_o,
  output logic btn_rise_o,
  output logic btn_fall_o
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             meta_q;
  logic             sync_q;
  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= btn_raw_i;
      sync_q <= meta_q;
    end
  end

  // Strobes default low so each lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sync_q) begin
            state_q <= ARM_HI;
            cnt_q   <= ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        ARM_HI: begin
          if (!sync_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= HIGH;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        HIGH: begin
          if (!sync_q) begin
            state_q <= ARM_LO;
            cnt_q   <= ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        ARM_LO: begin
          if (sync_q) begin
            state_q <= HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
      endcase
    end
  end

  assign btn_level_o = level_q;
  assign btn_rise_o  = rise_q;
  assign btn_fall_o  = fall_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button front end: N_BTN independent debounce channels.
// Ports: clk, rst_n, btn_raw -> btn_level, btn_rise, btn_fall.
module button_debounce
  import ui_pkg::*;
#(
  parameter int N_BTN         = 3,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall
);

  if (STABLE_CYCLES < 2 ||
      (64'd1 << CNT_W) <= 64'(STABLE_CYCLES)) begin : g_bad
    $error("button_debounce: bad STABLE_CYCLES/CNT_W");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw_i   (btn_raw[i]),
      .btn_level_o (btn_level[i]),
      .btn_rise_o  (btn_rise[i]),
      .btn_fall_o  (btn_fall[i])
    );
  end

endmodule
